// File: rtl/mig_eval_seq.sv
// mig_eval_seq: bit-parallel majority-inverter graph evaluator, one node per cycle
module mig_eval_seq #(
   parameter int NUM_PI = 5,
   parameter int MAX_NODES = 64,
   parameter int W = 32,
   localparam int IDXW = $clog2(1 + NUM_PI + MAX_NODES),
   localparam int OPW = IDXW + 1,
   localparam int AW = (MAX_NODES > 1) ? $clog2(MAX_NODES) : 1,
   localparam int NW = $clog2(MAX_NODES + 1)
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                cfg_we,
   input  logic [AW-1:0]       cfg_addr,
   input  logic [3*OPW-1:0]    cfg_data,
   input  logic [NW-1:0]       cfg_num_nodes,
   input  logic [OPW-1:0]      cfg_po,
   input  logic [NUM_PI*W-1:0] pi_data,
   input  logic                in_valid,
   output logic                in_ready,
   output logic [W-1:0]        out_data,
   output logic                out_valid,
   input  logic                out_ready
);
   typedef enum logic [1:0] {IDLE, EVAL, DONE} state_t;
   state_t state, state_n;
   logic [3*OPW-1:0] prog [MAX_NODES];
   logic [W-1:0] val [MAX_NODES];
   logic [W-1:0] src [2**IDXW];
   logic [NUM_PI*W-1:0] pi_q;
   logic [NW-1:0] n_q, n_in, k;
   logic [OPW-1:0] po_q, po_op;
   logic [3*OPW-1:0] ent;
   logic [W-1:0] op_a, op_b, op_c, maj, po_word;
   logic [IDXW-1:0] k_idx;
   logic accept, last, to_done;

   // In IDLE the source table shows the incoming pass (fresh pis, cleared nodes) so N=0 resolves immediately
   always_comb begin
      for (int i = 0; i < 2**IDXW; i++) src[i] = '0;
      for (int i = 0; i < NUM_PI; i++) src[1+i] = (state == IDLE) ? pi_data[i*W +: W] : pi_q[i*W +: W];
      for (int i = 0; i < MAX_NODES; i++) src[1+NUM_PI+i] = (state == IDLE) ? '0 : val[i];
   end

   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign accept    = in_valid & in_ready;
   assign n_in      = (cfg_num_nodes > NW'(MAX_NODES)) ? NW'(MAX_NODES) : cfg_num_nodes;
   assign ent       = prog[k[AW-1:0]];
   assign op_a      = src[ent[0 +: IDXW]] ^ {W{ent[OPW-1]}};
   assign op_b      = src[ent[OPW +: IDXW]] ^ {W{ent[2*OPW-1]}};
   assign op_c      = src[ent[2*OPW +: IDXW]] ^ {W{ent[3*OPW-1]}};
   assign maj       = (op_a & op_b) | (op_a & op_c) | (op_b & op_c);
   assign last      = (k == n_q - 1'b1);
   assign to_done   = (accept && n_in == '0) || (state == EVAL && last);
   assign po_op     = (state == IDLE) ? cfg_po : po_q;
   assign k_idx     = IDXW'(NUM_PI + 1) + IDXW'(k);
   // Output may name the node finishing this cycle; forward it rather than waiting a cycle
   assign po_word   = ((state == EVAL && po_op[IDXW-1:0] == k_idx) ? maj : src[po_op[IDXW-1:0]]) ^ {W{po_op[OPW-1]}};

   always_comb begin
      state_n = state;
      state_n = (state == IDLE) ? (accept ? ((n_in == '0) ? DONE : EVAL) : IDLE) :
                (state == EVAL) ? (last ? DONE : EVAL) :
                (out_ready ? IDLE : DONE);
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
         k <= '0;
         n_q <= '0;
         po_q <= '0;
         pi_q <= '0;
         out_data <= '0;
         for (int i = 0; i < MAX_NODES; i++) begin
            val[i] <= '0;
            prog[i] <= '0;
         end
      end else begin
         state <= state_n;
         if (in_ready && cfg_we) prog[cfg_addr] <= cfg_data;
         if (accept) begin
            pi_q <= pi_data;
            n_q <= n_in;
            po_q <= cfg_po;
            k <= '0;
            for (int i = 0; i < MAX_NODES; i++) val[i] <= '0;
         end else if (state == EVAL) begin
            val[k[AW-1:0]] <= maj;
            k <= k + 1'b1;
         end
         if (to_done) out_data <= po_word;
      end
   end
endmodule

// File: tb/tb_mig_eval_seq.sv
// tb_mig_eval_seq: directed and random passes against a scoreboard of model results
module tb_mig_eval_seq;
   logic clk = 0, rst_n = 0, cfg_we = 0, in_valid = 0, out_ready = 0;
   logic [5:0] cfg_addr = '0;
   logic [23:0] cfg_data = '0;
   logic [6:0] cfg_num_nodes = '0;
   logic [7:0] cfg_po = '0;
   logic [159:0] pi_data = '0;
   logic in_ready, out_valid;
   logic [31:0] out_data;
   int checks = 0, failures = 0;
   logic [31:0] exp_q [$];
   logic [23:0] m_prog [64];

   mig_eval_seq dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .cfg_num_nodes(cfg_num_nodes), .cfg_po(cfg_po), .pi_data(pi_data), .in_valid(in_valid),
      .in_ready(in_ready), .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready)
   );

   always #5 clk = ~clk;

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   function automatic logic [7:0] op(input bit inv, input int idx);
      return {inv, 7'(idx)};
   endfunction

   function automatic logic [159:0] pk(input logic [31:0] p0, p1, p2, p3, p4);
      return {p4, p3, p2, p1, p0};
   endfunction

   function automatic logic [31:0] wsel(input logic [7:0] o, input logic [159:0] pis, input logic [31:0] v [64]);
      int i;
      logic [31:0] w;
      i = int'(o[6:0]);
      w = (i == 0) ? 32'h0 : (i <= 5) ? pis[(i-1)*32 +: 32] : (i <= 69) ? v[i-6] : 32'h0;
      return w ^ {32{o[7]}};
   endfunction

   function automatic logic [31:0] model(input logic [159:0] pis, input int n, input logic [7:0] po);
      logic [31:0] v [64];
      logic [31:0] a, b, c;
      int nn;
      nn = (n > 64) ? 64 : n;
      for (int i = 0; i < 64; i++) v[i] = '0;
      for (int j = 0; j < nn; j++) begin
         a = wsel(m_prog[j][7:0], pis, v);
         b = wsel(m_prog[j][15:8], pis, v);
         c = wsel(m_prog[j][23:16], pis, v);
         v[j] = (a & b) | (a & c) | (b & c);
      end
      return wsel(po, pis, v);
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
      checks++;
      assert (obs === expv) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
      end
   endtask

   task automatic prog_node(input int addr, input logic [7:0] a, b, c);
      cfg_we = 1;
      cfg_addr = 6'(addr);
      cfg_data = {c, b, a};
      @(posedge clk);
      m_prog[addr] = {c, b, a};
      @(negedge clk);
      cfg_we = 0;
   endtask

   task automatic run(input string tag, input logic [159:0] pis, input int n, input logic [7:0] po,
                      input logic [31:0] expv, input int hold, input bit wa, input int wa_addr,
                      input logic [23:0] wa_data);
      int cyc;
      logic [31:0] obs;
      check({tag, " in_ready"}, in_ready, 1);
      pi_data = pis;
      cfg_num_nodes = 7'(n);
      cfg_po = po;
      in_valid = 1;
      if (wa) begin
         cfg_we = 1;
         cfg_addr = 6'(wa_addr);
         cfg_data = wa_data;
      end
      @(posedge clk);
      exp_q.push_back(expv);
      @(negedge clk);
      cyc = 1;
      if (hold > 0) begin
         cfg_we = 1;
         cfg_addr = 6'd0;
         cfg_data = 24'($urandom);
         pi_data = pk($urandom, $urandom, $urandom, $urandom, $urandom);
         cfg_num_nodes = 7'd1;
      end else begin
         in_valid = 0;
         cfg_we = 0;
      end
      while (!out_valid && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      check({tag, " latency"}, 64'(cyc), 64'(((n > 64) ? 64 : n) + 1));
      for (int h = 0; h < hold; h++) begin
         check({tag, " held_data"}, out_data, exp_q[0]);
         check({tag, " held_in_ready"}, in_ready, 0);
         check({tag, " held_valid"}, out_valid, 1);
         @(negedge clk);
      end
      out_ready = 1;
      obs = out_data;
      @(posedge clk);
      check({tag, " data"}, obs, exp_q.pop_front());
      @(negedge clk);
      out_ready = 0;
      in_valid = 0;
      cfg_we = 0;
      check({tag, " idle_ready"}, in_ready, 1);
      check({tag, " idle_valid"}, out_valid, 0);
   endtask

   initial begin
      logic [159:0] pis;
      int n, seen;
      logic [7:0] po;
      for (int i = 0; i < 64; i++) m_prog[i] = '0;
      repeat (3) @(negedge clk);
      check("reset in_ready", in_ready, 1);
      check("reset out_valid", out_valid, 0);
      check("reset out_data", out_data, 0);
      rst_n = 1;
      @(negedge clk);
      run("reset_prog", pk($urandom, $urandom, $urandom, $urandom, $urandom), 3, op(1, 8), 32'hFFFFFFFF, 0, 0, 0, 0);
      prog_node(0, op(1, 0), op(0, 1), op(0, 2));
      run("or", pk(32'hF0F0F0F0, 32'hFF00FF00, 0, 0, 0), 1, op(0, 6), 32'hFFF0FFF0, 0, 0, 0, 0);
      run("zero_nodes", pk(0, 0, 32'h0000FFFF, 0, 0), 0, op(1, 3), 32'hFFFF0000, 0, 0, 0, 0);
      prog_node(0, op(0, 0), op(0, 1), op(0, 2));
      prog_node(1, op(1, 0), op(1, 6), op(0, 5));
      pis = pk(32'hC, 32'hA, 0, 0, 0);
      run("chain", pis, 2, op(0, 7), 32'hFFFFFFF7, 0, 0, 0, 0);
      run("backpressure", pis, 2, op(0, 7), 32'hFFFFFFF7, 5, 0, 0, 0);
      run("bp_rerun", pis, 2, op(0, 7), 32'hFFFFFFF7, 0, 0, 0, 0);
      m_prog[2] = {op(0, 4), op(0, 4), op(0, 4)};
      run("write_accept", pk(0, 0, 0, 32'h12345678, 0), 3, op(0, 8), 32'h12345678, 0, 1, 2, {op(0, 4), op(0, 4), op(0, 4)});
      prog_node(3, op(1, 9), op(1, 10), op(0, 0));
      run("self_ref", pk(1, 2, 3, 4, 5), 4, op(0, 9), 32'hFFFFFFFF, 0, 0, 0, 0);
      run("beyond_n", pk(1, 2, 3, 4, 5), 3, op(0, 9), 32'h0, 0, 0, 0, 0);
      run("idx_over", pk($urandom, $urandom, $urandom, $urandom, $urandom), 0, op(1, 100), 32'hFFFFFFFF, 0, 0, 0, 0);
      run("idx_70", pk($urandom, $urandom, $urandom, $urandom, $urandom), 0, op(0, 70), 32'h0, 0, 0, 0, 0);
      run("clamp", pk(0, 0, 0, 0, 0), 100, op(1, 69), 32'hFFFFFFFF, 0, 0, 0, 0);
      for (int it = 0; it < 6; it++) begin
         for (int j = 0; j < 8; j++)
            prog_node(j, op($urandom_range(0, 1), $urandom_range(0, 13)), op($urandom_range(0, 1), $urandom_range(0, 13)),
                      op($urandom_range(0, 1), $urandom_range(0, 13)));
         pis = pk($urandom, $urandom, $urandom, $urandom, $urandom);
         n = $urandom_range(0, 8);
         po = op($urandom_range(0, 1), $urandom_range(0, 13));
         run("random", pis, n, po, model(pis, n, po), 0, 0, 0, 0);
      end
      pi_data = pk($urandom, $urandom, $urandom, $urandom, $urandom);
      cfg_num_nodes = 7'd10;
      cfg_po = op(0, 15);
      in_valid = 1;
      @(posedge clk);
      @(negedge clk);
      in_valid = 0;
      repeat (4) @(negedge clk);
      check("mid_eval busy", in_ready, 0);
      rst_n = 0;
      @(negedge clk);
      check("mid_eval rst valid", out_valid, 0);
      rst_n = 1;
      for (int i = 0; i < 64; i++) m_prog[i] = '0;
      @(negedge clk);
      check("mid_eval ready", in_ready, 1);
      seen = 0;
      repeat (12) begin
         @(negedge clk);
         if (out_valid) seen++;
      end
      check("mid_eval no_valid", 64'(seen), 0);
      pis = pk($urandom, $urandom, $urandom, $urandom, $urandom);
      run("rst_rerun", pis, 10, op(0, 15), 32'h0, 0, 0, 0, 0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end
endmodule
